// File: rtl/access_pkg.sv
// Shared types and default timing constants for the access sequencer.
// Holds the FSM state encoding and the timer width helper.
package access_pkg;

    localparam int unsigned STATE_W          = 3;
    localparam int unsigned GRANT_CYCLES_DEF = 8;
    localparam int unsigned LOCK_CYCLES_DEF  = 16;
    localparam int unsigned MAX_FAIL_DEF     = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_GRANTED = 3'd3,
        ST_DENIED  = 3'd4,
        ST_LOCKED  = 3'd5
    } state_e;

    // Bits needed to hold n-1, never less than one bit.
    function automatic int unsigned timer_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/window_timer.sv
// Loadable down-counter with a zero flag; shared by the grant and lockout windows.
module window_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/access_sequencer.sv
// Authentication sequencer: latches a user code, waits for the external decoder,
// then opens a timed access window or counts a denial, locking out after repeated failures.
//
// state   | meaning
// IDLE    | waiting for REQ
// LATCH   | user code captured, decoder settling
// CHECK   | decoder result sampled
// GRANTED | access window open, timer running
// DENIED  | single-cycle denial pulse
// LOCKED  | lockout window, timer running
module access_sequencer
    import access_pkg::*;
#(
    parameter int unsigned GRANT_CYCLES = GRANT_CYCLES_DEF,
    parameter int unsigned LOCK_CYCLES  = LOCK_CYCLES_DEF,
    parameter int unsigned MAX_FAIL     = MAX_FAIL_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ,
    input  logic [2:0] U_IN,
    input  logic       REL,
    output logic [2:0] AU_U,
    input  logic [2:0] AU_CK,
    input  logic       AU_V,
    output logic       ACK,
    output logic       GRANT,
    output logic [2:0] PROFILE,
    output logic       DENY,
    output logic       LOCK,
    output logic       BUSY
);

    localparam int unsigned WIN_MAX = (GRANT_CYCLES > LOCK_CYCLES) ? GRANT_CYCLES : LOCK_CYCLES;
    localparam int unsigned TIMER_W = timer_width(WIN_MAX);

    state_e       state_q;
    logic [2:0]   au_u_q;
    logic         ack_q;
    logic         grant_q;
    logic [2:0]   profile_q;
    logic         deny_q;
    logic         lock_q;
    logic [1:0]   fail_q;

    logic               fail_last;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_val;
    logic               timer_dec;
    logic               timer_zero;

    assign fail_last = (({1'b0, fail_q} + 3'd1) == 3'(MAX_FAIL));

    always_comb begin
        timer_load     = (state_q == ST_CHECK) && (AU_V || fail_last);
        timer_load_val = AU_V ? TIMER_W'(GRANT_CYCLES - 1) : TIMER_W'(LOCK_CYCLES - 1);
        timer_dec      = (state_q == ST_GRANTED) || (state_q == ST_LOCKED);
    end

    window_timer #(
        .WIDTH (TIMER_W)
    ) u_window_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (timer_load),
        .load_val_i (timer_load_val),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            au_u_q    <= '0;
            ack_q     <= 1'b0;
            grant_q   <= 1'b0;
            profile_q <= '0;
            deny_q    <= 1'b0;
            lock_q    <= 1'b0;
            fail_q    <= '0;
        end else begin
            ack_q  <= 1'b0;
            deny_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (REQ) begin
                        au_u_q  <= U_IN;
                        ack_q   <= 1'b1;
                        state_q <= ST_LATCH;
                    end
                end
                ST_LATCH: state_q <= ST_CHECK;
                ST_CHECK: begin
                    if (AU_V) begin
                        grant_q   <= 1'b1;
                        profile_q <= AU_CK;
                        fail_q    <= '0;
                        state_q   <= ST_GRANTED;
                    end else if (fail_last) begin
                        // lockout replaces the denial pulse
                        fail_q  <= '0;
                        lock_q  <= 1'b1;
                        state_q <= ST_LOCKED;
                    end else begin
                        fail_q  <= fail_q + 2'd1;
                        deny_q  <= 1'b1;
                        state_q <= ST_DENIED;
                    end
                end
                ST_GRANTED: begin
                    if (timer_zero || REL) begin
                        grant_q   <= 1'b0;
                        profile_q <= '0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_DENIED: state_q <= ST_IDLE;
                ST_LOCKED: begin
                    if (timer_zero) begin
                        lock_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign AU_U    = au_u_q;
    assign ACK     = ack_q;
    assign GRANT   = grant_q;
    assign PROFILE = profile_q;
    assign DENY    = deny_q;
    assign LOCK    = lock_q;
    assign BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_access_sequencer.sv
// Directed self-checking bench for access_sequencer with GRANT=4, LOCK=6, MAX_FAIL=3.
module tb_access_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [2:0] u_in;
    logic       rel;
    logic [2:0] au_u;
    logic [2:0] au_ck;
    logic       au_v;
    logic       ack;
    logic       grant;
    logic [2:0] profile;
    logic       deny;
    logic       lock;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    int ack_cnt;

    access_sequencer #(
        .GRANT_CYCLES (4),
        .LOCK_CYCLES  (6),
        .MAX_FAIL     (3)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .REQ     (req),
        .U_IN    (u_in),
        .REL     (rel),
        .AU_U    (au_u),
        .AU_CK   (au_ck),
        .AU_V    (au_v),
        .ACK     (ack),
        .GRANT   (grant),
        .PROFILE (profile),
        .DENY    (deny),
        .LOCK    (lock),
        .BUSY    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ack"},     32'(ack),     32'd0);
        chk({tag, ".grant"},   32'(grant),   32'd0);
        chk({tag, ".profile"}, 32'(profile), 32'd0);
        chk({tag, ".deny"},    32'(deny),    32'd0);
        chk({tag, ".lock"},    32'(lock),    32'd0);
        chk({tag, ".busy"},    32'(busy),    32'd0);
    endtask

    // Issues one request and advances to just after the CHECK edge.
    task automatic do_req(input string tag, input logic [2:0] u, input logic v, input logic [2:0] ck);
        au_v  = v;
        au_ck = ck;
        u_in  = u;
        req   = 1'b1;
        step();
        chk({tag, ".ack"},  32'(ack),  32'd1);
        chk({tag, ".au_u"}, 32'(au_u), 32'(u));
        req = 1'b0;
        step();
        chk({tag, ".ack_clr"}, 32'(ack), 32'd0);
        step();
    endtask

    task automatic do_deny(input string tag);
        do_req(tag, 3'd3, 1'b0, 3'd0);
        chk({tag, ".deny"}, 32'(deny), 32'd1);
        chk({tag, ".lock"}, 32'(lock), 32'd0);
        step();
        chk({tag, ".deny_clr"}, 32'(deny), 32'd0);
        chk({tag, ".idle"},     32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; u_in = '0; rel = 1'b0; au_ck = '0; au_v = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        chk("reset.au_u", 32'(au_u), 32'd0);
        rst = 1'b0;
        step();

        // valid user, full-length grant
        do_req("valid", 3'd2, 1'b1, 3'd5);
        chk("valid.grant1", 32'(grant),   32'd1);
        chk("valid.prof1",  32'(profile), 32'd5);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("valid.grant_hold", 32'(grant),   32'd1);
            chk("valid.prof_hold",  32'(profile), 32'd5);
        end
        step();
        chk_all_zero("valid.end");

        // early release in second grant cycle
        do_req("rel", 3'd1, 1'b1, 3'd6);
        chk("rel.grant1", 32'(grant), 32'd1);
        step();
        chk("rel.grant2", 32'(grant), 32'd1);
        rel = 1'b1;
        step();
        rel = 1'b0;
        chk("rel.grant_off", 32'(grant),   32'd0);
        chk("rel.prof_off",  32'(profile), 32'd0);
        chk("rel.busy",      32'(busy),    32'd0);

        // three denials lead to lockout; REQ and REL during lock ignored
        do_deny("deny1");
        do_deny("deny2");
        do_req("deny3", 3'd4, 1'b0, 3'd0);
        chk("lock.lock1", 32'(lock), 32'd1);
        chk("lock.nodeny", 32'(deny), 32'd0);
        req = 1'b1;
        rel = 1'b1;
        for (int i = 2; i <= 6; i++) begin
            step();
            chk("lock.hold",  32'(lock), 32'd1);
            chk("lock.noack", 32'(ack),  32'd0);
        end
        req = 1'b0;
        rel = 1'b0;
        step();
        chk("lock.off",  32'(lock), 32'd0);
        chk("lock.idle", 32'(busy), 32'd0);

        // grant clears fail count
        do_deny("pre1");
        do_deny("pre2");
        do_req("mid", 3'd5, 1'b1, 3'd2);
        chk("mid.grant", 32'(grant),   32'd1);
        chk("mid.prof",  32'(profile), 32'd2);
        rel = 1'b1;
        step();
        rel = 1'b0;
        do_deny("post1");
        do_deny("post2");

        // third denial locks; reset in lock cycle 3 aborts it
        do_req("rlock", 3'd0, 1'b0, 3'd0);
        chk("rlock.lock1", 32'(lock), 32'd1);
        step();
        step();
        chk("rlock.lock3", 32'(lock), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("rlock.rst");
        chk("rlock.au_u", 32'(au_u), 32'd0);
        step();
        chk("rlock.nolock", 32'(lock), 32'd0);
        do_req("after", 3'd6, 1'b1, 3'd3);
        chk("after.grant", 32'(grant),   32'd1);
        chk("after.prof",  32'(profile), 32'd3);
        rel = 1'b1;
        step();
        rel = 1'b0;
        // fail count cleared by reset: one denial must not lock
        do_deny("after_deny");

        // REQ held high: one ACK per IDLE visit, period 7 cycles
        au_v  = 1'b1;
        au_ck = 3'd7;
        u_in  = 3'd1;
        req   = 1'b1;
        step();
        chk("b2b.ack1",  32'(ack),  32'd1);
        chk("b2b.au_u1", 32'(au_u), 32'd1);
        u_in = 3'd4;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ack) ack_cnt++;
            if (grant) chk("b2b.au_u_stable", 32'(au_u), 32'd1);
        end
        chk("b2b.ack_cnt", 32'(ack_cnt), 32'd0);
        chk("b2b.idle",    32'(busy),    32'd0);
        step();
        chk("b2b.ack2",  32'(ack),  32'd1);
        chk("b2b.au_u2", 32'(au_u), 32'd4);
        req = 1'b0;
        step();
        step();
        chk("b2b.grant2", 32'(grant),   32'd1);
        chk("b2b.prof2",  32'(profile), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/access_sequencer.md
ACCESS_SEQUENCER -- requirements
Module: access_sequencer

Interface
REQ-001 The block SHALL have parameter GRANT_CYCLES, default 8, meaning access-window length in clock cycles (>=1).
REQ-002 The block SHALL have parameter LOCK_CYCLES, default 16, meaning lockout length in clock cycles (>=1).
REQ-003 The block SHALL have parameter MAX_FAIL, default 3, meaning consecutive denials that trigger lockout (1..3).
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 REQ  input  1  authentication request, level-sampled.
REQ-007 U_IN  input  3  user code presented with REQ.
REQ-008 REL  input  1  early release of an active grant.
REQ-009 AU_U  output  3  user code driven to the authentication decoder.
REQ-010 AU_CK  input  3  profile code returned by the decoder.
REQ-011 AU_V  input  1  valid-user flag returned by the decoder.
REQ-012 ACK  output  1  one-cycle request-accepted pulse.
REQ-013 GRANT  output  1  access window active.
REQ-014 PROFILE  output  3  profile of granted user; 0 when GRANT=0.
REQ-015 DENY  output  1  one-cycle denial pulse.
REQ-016 LOCK  output  1  lockout active.
REQ-017 BUSY  output  1  high whenever state is not IDLE (combinational from state).

Function
REQ-018 The FSM SHALL have states IDLE, LATCH, CHECK, GRANTED, DENIED, LOCKED; ACK, GRANT, PROFILE, DENY, LOCK and AU_U SHALL be registered.
REQ-019 In IDLE with REQ=1 at edge k, the block SHALL capture U_IN into the user register (driving AU_U), set ACK=1, and go to LATCH.
REQ-020 At edge k+1 the block SHALL clear ACK and go to CHECK (one settle cycle for the decoder).
REQ-021 At edge k+2 in CHECK with AU_V=1, the block SHALL set GRANT=1, PROFILE=AU_CK, clear the fail counter, load timer with GRANT_CYCLES-1, go to GRANTED.
REQ-022 At edge k+2 in CHECK with AU_V=0 and fail_count+1<MAX_FAIL, the block SHALL increment fail_count, set DENY=1, go to DENIED.
REQ-023 At edge k+2 in CHECK with AU_V=0 and fail_count+1=MAX_FAIL, the block SHALL clear fail_count, set LOCK=1, load timer with LOCK_CYCLES-1, go to LOCKED (no DENY pulse).
REQ-024 In GRANTED, GRANT SHALL stay high for exactly GRANT_CYCLES cycles; on timer=0 or REL=1 (either or both) the block SHALL clear GRANT and PROFILE and return to IDLE.
REQ-025 DENIED SHALL last one cycle, clear DENY, return to IDLE.
REQ-026 In LOCKED, LOCK SHALL stay high exactly LOCK_CYCLES cycles, then clear and return to IDLE.
REQ-027 REQ outside IDLE SHALL be ignored (no ACK, no capture); a REQ still high on return to IDLE SHALL start a new request.
REQ-028 REL outside GRANTED SHALL be ignored.
REQ-029 fail_count SHALL be 2 bits, saturate-free by construction (cleared at MAX_FAIL), persist across IDLE.
REQ-030 AU_U SHALL hold the captured code until the next capture.

Reset
REQ-031 RST=1 SHALL, at the next edge, force IDLE, AU_U=0, ACK=0, GRANT=0, PROFILE=0, DENY=0, LOCK=0, fail_count=0, timer=0, with priority over all other inputs.
REQ-032 RST asserted mid-grant or mid-lockout SHALL abort it; no residual lockout after reset.

Structure
REQ-033 Package access_pkg SHALL hold the state enumeration, state width, and default GRANT_CYCLES/LOCK_CYCLES/MAX_FAIL constants.
REQ-034 One sub-module window_timer (loadable down-counter with zero flag, width from max(GRANT_CYCLES,LOCK_CYCLES)) SHALL be shared by GRANTED and LOCKED.
REQ-035 The decoder SHALL sit outside this block, connected via AU_U/AU_CK/AU_V at top level.

Verification (GRANT_CYCLES=4, LOCK_CYCLES=6, MAX_FAIL=3)
REQ-036 Valid user: REQ=1, U_IN=2, decoder AU_V=1, AU_CK=5 -> ACK at k+1, GRANT=1/PROFILE=5 from k+3 for 4 cycles, then IDLE.
REQ-037 Early release: grant active, REL=1 in second grant cycle -> GRANT, PROFILE=0 next edge, BUSY=0.
REQ-038 Three invalid requests (AU_V=0) -> DENY pulses on first two, third gives LOCK=1 for 6 cycles, no DENY; REQ during lock yields no ACK.
REQ-039 Two denials then valid request -> GRANT; subsequent two denials do not lock (counter cleared).
REQ-040 RST asserted in cycle 3 of LOCKED -> all outputs 0 next edge; new valid REQ grants normally.
REQ-041 REQ held high continuously with AU_V=1 -> back-to-back requests, one ACK per IDLE visit, AU_U stable during each grant.
